frida_seq_ctrl: RTL and testbench
=================================

# frida_seq_ctrl

Conversion sequencer for the FRIDA ADC array. It generates the four shared phase clocks `seq_init`, `seq_samp`, `seq_cmp` and `seq_logic` that drive all 16 ADCs. It also captures the multiplexed comparator decision after each compare phase and presents the assembled result word on a valid/ready interface. It sits beside `frida_core` and replaces the pad-driven sequencing for on-chip, self-timed conversions.

## Interface
- `NBITS`, 16: maximum compare cycles per conversion, and the result width.
- `CNTW`, 8: width of the phase-length configuration fields.
- `clk` in 1: sequencer clock; all state updates on its rising edge.
- `rst_b` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request to begin a conversion; honoured only in IDLE.
- `abort` in 1: synchronous abort; highest priority.
- `cfg_init_len` in CNTW: number of INIT cycles; 0 is treated as 1.
- `cfg_samp_len` in CNTW: number of SAMP cycles; 0 is treated as 1.
- `cfg_ncomp` in 5: compare cycles per conversion; 0 is treated as 1, values above NBITS are clamped to NBITS.
- `cfg_continuous` in 1: after DONE, restart at INIT without a new `start`.
- `comp_in` in 1: comparator decision (the `comp_out` of `frida_core`).
- `seq_init`, `seq_samp`, `seq_cmp`, `seq_logic` out 1 each: phase clocks to the ADC array.
- `busy` out 1: high in every state except IDLE.
- `res_data` out NBITS: conversion result, MSB-first, zero-extended.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `overrun` out 1: sticky flag; a result was dropped because the output register was full.

## Operation
- States: IDLE, INIT, SAMP, COMP, LOGIC, DONE. The state register is one-hot.
- `seq_init` = INIT flop, `seq_samp` = SAMP flop, `seq_cmp` = COMP flop, `seq_logic` = LOGIC flop. The phase outputs are driven directly by these flops, so they are glitch-free and never overlap.
- IDLE → INIT on `start`. On that transition:
  - `cfg_*` are latched; later changes to `cfg_*` are ignored until the next latch.
  - the shift register and the bit counter are cleared;
  - `overrun` is cleared.
- INIT lasts I = max(`cfg_init_len`, 1) cycles, then moves to SAMP.
- SAMP lasts S = max(`cfg_samp_len`, 1) cycles, then moves to COMP.
- COMP lasts 1 cycle, then LOGIC lasts 1 cycle. This COMP/LOGIC pair repeats N times, where N = clamp(`cfg_ncomp`, 1, NBITS). After the N-th LOGIC the state moves to DONE.
- `comp_in` is sampled on the clock edge that ends each COMP cycle and shifted in at the LSB. After N bits, the first decision sits in bit N-1 and bits NBITS-1..N are 0.
- DONE lasts 1 cycle:
  - If `res_valid` is 0, or `res_ready` is 1 in the same cycle, then `res_data` is loaded and `res_valid` is set.
  - Otherwise the new result is discarded, `res_data` is held unchanged, and `overrun` is set.
- DONE → INIT if the latched continuous bit is set; `cfg_*` are re-latched at this transition. Otherwise DONE → IDLE.
- `res_valid` falls on a cycle with `res_valid` and `res_ready` both high, unless DONE reloads it in that same cycle.
- `abort` in any state:
  - next state is IDLE;
  - all `seq_*` are low in the next cycle;
  - the partial result is discarded;
  - `res_valid`, `res_data` and `overrun` are unaffected.
- `abort` and `start` in the same cycle: `abort` wins and the state stays in IDLE.
- `start` while `busy` is high is ignored, with no queuing.

## Timing
- Reset (`rst_b` low, asynchronous): state is IDLE; all `seq_*`, `busy`, `res_valid` and `overrun` are 0; `res_data` is 0.
- Reset applied mid-conversion: all outputs reach their reset values immediately, without waiting for a clock edge.
- `start` sampled at edge k: `seq_init` and `busy` are high from edge k+1.
- Conversion length is I + S + 2N + 1 cycles. `res_valid` rises at edge k+1+I+S+2N+1.
- Back-to-back conversions in continuous mode have 0 idle cycles: INIT follows DONE directly.
- Minimum conversion: 1 + 1 + 2 + 1 = 5 cycles.

## Structure
- Package `frida_seq_pkg` holds:
  - the state enum with one-hot encoding;
  - the default NBITS and CNTW;
  - the `cfg_ncomp` width constant.
- Sub-module `frida_seq_timer`: a CNTW-bit loadable down-counter with an `expire` output. It is reused to time both INIT and SAMP.
- Bit counter and shift register live in the top level.

## Test plan
- Reset release, then `start` with init=3, samp=2, ncomp=4, `comp_in`=1,0,1,1 per COMP:
  - expect `seq_init` high for 3 cycles, `seq_samp` for 2, then four alternating `seq_cmp`/`seq_logic` pairs;
  - expect `res_data`=0x000B with `res_valid` 14 cycles after `busy` rises.
- init=0, samp=0, ncomp=0: expect a 5-cycle conversion with 1 decision bit.
- ncomp=20 with NBITS=16: expect 16 compares and an all-ones result when `comp_in` is held at 1.
- Continuous mode with `res_ready` held 0:
  - the first result is held;
  - the second DONE sets `overrun` and leaves `res_data` unchanged;
  - a new `start` from IDLE clears `overrun`.
- Abort during the third COMP:
  - all `seq_*` go low the next cycle, `busy` goes to 0, and `res_valid` is unchanged;
  - a `start` issued 1 cycle later runs normally.
- Assert `rst_b` low in mid-SAMP: all outputs read 0 before the next clock edge.

Source files
------------

// File: rtl/frida_seq_pkg.sv
// Shared types and constants for the FRIDA conversion sequencer.
package frida_seq_pkg;

  localparam int unsigned NBITS_DEF = 16;
  localparam int unsigned CNTW_DEF  = 8;
  localparam int unsigned NCOMP_W   = 5;
  localparam int unsigned ST_W      = 6;

  localparam int unsigned IDX_IDLE  = 0;
  localparam int unsigned IDX_INIT  = 1;
  localparam int unsigned IDX_SAMP  = 2;
  localparam int unsigned IDX_COMP  = 3;
  localparam int unsigned IDX_LOGIC = 4;
  localparam int unsigned IDX_DONE  = 5;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 6'b000001,
    ST_INIT  = 6'b000010,
    ST_SAMP  = 6'b000100,
    ST_COMP  = 6'b001000,
    ST_LOGIC = 6'b010000,
    ST_DONE  = 6'b100000
  } state_e;

  // Effective compare count: 0 reads as 1, anything above nmax reads as nmax.
  function automatic int unsigned clamp_ncomp(input logic [NCOMP_W-1:0] v,
                                              input int unsigned nmax);
    int unsigned n;
    n = 32'(v);
    if (n == 0) begin
      n = 1;
    end else if (n > nmax) begin
      n = nmax;
    end
    return n;
  endfunction

endpackage

// File: rtl/frida_seq_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module frida_seq_timer
  import frida_seq_pkg::*;
#(
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            i_load,
  input  logic [CNTW-1:0] i_load_val,
  output logic            o_expire_c
);

  logic [CNTW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNTW'(1);
    end
  end

  assign o_expire_c = (r_cnt == '0);

endmodule

// File: rtl/frida_seq_ctrl.sv
// Self-timed conversion sequencer: one-hot phase FSM driving the shared ADC
// phase clocks, plus comparator capture and a valid/ready result register.
module frida_seq_ctrl
  import frida_seq_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned CNTW  = CNTW_DEF
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start,
  input  logic               abort,
  input  logic [CNTW-1:0]    cfg_init_len,
  input  logic [CNTW-1:0]    cfg_samp_len,
  input  logic [NCOMP_W-1:0] cfg_ncomp,
  input  logic               cfg_continuous,
  input  logic               comp_in,
  output logic               seq_init,
  output logic               seq_samp,
  output logic               seq_cmp,
  output logic               seq_logic,
  output logic               busy,
  output logic [NBITS-1:0]   res_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               overrun
);

  localparam int unsigned BCW = $clog2(NBITS + 1);

  state_e            r_state;
  state_e            w_next;
  logic [CNTW-1:0]   r_samp_len;
  logic [BCW-1:0]    r_ncomp;
  logic              r_cont;
  logic [BCW-1:0]    r_bitcnt;
  logic [NBITS-1:0]  r_shift;
  logic [NBITS-1:0]  r_res_data;
  logic              r_res_valid;
  logic              r_overrun;

  logic              w_expire;
  logic              w_go;
  logic              w_latch;
  logic              w_tmr_load;
  logic [CNTW-1:0]   w_tmr_val;
  logic              w_shift_en;
  logic              w_res_load;
  logic              w_ovr_set;

  frida_seq_timer #(.CNTW(CNTW)) u_timer (
    .clk        (clk),
    .rst_b      (rst_b),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire_c (w_expire)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) w_next = ST_INIT;
        ST_INIT:  if (w_expire) w_next = ST_SAMP;
        ST_SAMP:  if (w_expire) w_next = ST_COMP;
        ST_COMP:  w_next = ST_LOGIC;
        ST_LOGIC: w_next = (r_bitcnt == r_ncomp) ? ST_DONE : ST_COMP;
        ST_DONE:  w_next = r_cont ? ST_INIT : ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Control strobes; abort suppresses every side effect except the handshake.
  always_comb begin
    w_go       = 1'b0;
    w_latch    = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_shift_en = 1'b0;
    w_res_load = 1'b0;
    w_ovr_set  = 1'b0;
    if (!abort) begin
      w_go       = start && (r_state == ST_IDLE);
      w_latch    = w_go || (r_cont && (r_state == ST_DONE));
      w_tmr_load = w_latch || (w_expire && (r_state == ST_INIT));
      w_shift_en = (r_state == ST_COMP);
      w_res_load = (r_state == ST_DONE) && (!r_res_valid || res_ready);
      w_ovr_set  = (r_state == ST_DONE) && r_res_valid && !res_ready;
    end
    if (r_state == ST_INIT) begin
      w_tmr_val = (r_samp_len == '0) ? '0 : r_samp_len - CNTW'(1);
    end else begin
      w_tmr_val = (cfg_init_len == '0) ? '0 : cfg_init_len - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_samp_len <= '0;
      r_ncomp    <= '0;
      r_cont     <= 1'b0;
    end else if (w_latch) begin
      r_samp_len <= cfg_samp_len;
      r_ncomp    <= BCW'(clamp_ncomp(cfg_ncomp, NBITS));
      r_cont     <= cfg_continuous;
    end
  end

  // Decisions enter at the LSB, so the first one ends up in bit N-1.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (w_latch) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (w_shift_en) begin
      r_bitcnt <= r_bitcnt + BCW'(1);
      r_shift  <= {r_shift[NBITS-2:0], comp_in};
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else if (w_res_load) begin
      r_res_data  <= r_shift;
      r_res_valid <= 1'b1;
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_overrun <= 1'b0;
    end else if (w_go) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end
  end

  assign seq_init  = r_state[IDX_INIT];
  assign seq_samp  = r_state[IDX_SAMP];
  assign seq_cmp   = r_state[IDX_COMP];
  assign seq_logic = r_state[IDX_LOGIC];
  assign busy      = ~r_state[IDX_IDLE];
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_frida_seq_ctrl.sv
// Directed bench for frida_seq_ctrl with a result scoreboard queue.
module tb_frida_seq_ctrl;

  localparam int NB = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cfg_init_len = '0;
  logic [CW-1:0] cfg_samp_len = '0;
  logic [4:0]    cfg_ncomp = '0;
  logic          cfg_continuous = 1'b0;
  logic          comp_in = 1'b0;
  logic          seq_init, seq_samp, seq_cmp, seq_logic, busy;
  logic [NB-1:0] res_data;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          overrun;

  int errors = 0;
  int checks = 0;
  logic [NB-1:0] exp_q[$];

  frida_seq_ctrl #(.NBITS(NB), .CNTW(CW)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
    .cfg_init_len(cfg_init_len), .cfg_samp_len(cfg_samp_len),
    .cfg_ncomp(cfg_ncomp), .cfg_continuous(cfg_continuous), .comp_in(comp_in),
    .seq_init(seq_init), .seq_samp(seq_samp), .seq_cmp(seq_cmp),
    .seq_logic(seq_logic), .busy(busy), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] phases();
    return {seq_init, seq_samp, seq_cmp, seq_logic};
  endfunction

  function automatic int eff_len(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int eff_n(input int v);
    return (v == 0) ? 1 : ((v > NB) ? NB : v);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_conv(input int init, input int samp, input int nc,
                            input logic cont, input logic [NB-1:0] bits);
    logic [NB-1:0] m;
    m = 16'hFFFF;
    m = m >> (NB - eff_n(nc));
    cfg_init_len   = CW'(init);
    cfg_samp_len   = CW'(samp);
    cfg_ncomp      = 5'(nc);
    cfg_continuous = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(bits & m);
  endtask

  // Walks a whole conversion from its first INIT cycle through DONE.
  // mode 1 scrambles all cfg inputs, mode 2 only drops cfg_continuous.
  task automatic run_trace(input string tag, input int init, input int samp,
                           input int nc, input logic [NB-1:0] bits, input int mode);
    int ie, se, ne, total, k;
    logic [3:0] expph;
    ie = eff_len(init);
    se = eff_len(samp);
    ne = eff_n(nc);
    total = ie + se + 2 * ne + 1;
    for (int c = 0; c < total; c++) begin
      if (c < ie)                 expph = 4'b1000;
      else if (c < ie + se)       expph = 4'b0100;
      else if (c == total - 1)    expph = 4'b0000;
      else if (((c - ie - se) % 2) == 0) expph = 4'b0010;
      else                        expph = 4'b0001;
      check($sformatf("%s phase c%0d", tag, c), 32'(phases()), 32'(expph));
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
      if (expph == 4'b0010) begin
        k = ne - 1 - (c - ie - se) / 2;
        comp_in = bits[k];
      end else begin
        comp_in = 1'($urandom);
      end
      if (c == 0 && mode == 1) begin
        cfg_init_len   = CW'($urandom);
        cfg_samp_len   = CW'($urandom);
        cfg_ncomp      = 5'($urandom);
        cfg_continuous = ~cfg_continuous;
      end else if (c == 0 && mode == 2) begin
        cfg_continuous = 1'b0;
      end
      tick();
    end
  endtask

  task automatic take_result(input string tag);
    logic [NB-1:0] e;
    check({tag, " valid"}, 32'(res_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " data"}, 32'(res_data), 32'(e));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, " drained"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #1 rst_b = 1'b0;
    #1;
    check("rst phases", 32'(phases()), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst valid", 32'(res_valid), 32'd0);
    check("rst data", 32'(res_data), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
    check("idle busy", 32'(busy), 32'd0);

    // Basic conversion: 1,0,1,1 -> 0x000B after 14 busy cycles.
    start_conv(3, 2, 4, 1'b0, 16'h000B);
    run_trace("t1", 3, 2, 4, 16'h000B, 1);
    check("t1 idle", 32'(busy), 32'd0);
    take_result("t1");

    // Zero lengths all read as 1: five-cycle conversion, one bit.
    start_conv(0, 0, 0, 1'b0, 16'h0001);
    run_trace("t2", 0, 0, 0, 16'h0001, 1);
    take_result("t2");

    // Continuous mode with the consumer stalled.
    start_conv(2, 1, 3, 1'b1, 16'h0005);
    run_trace("t4a", 2, 1, 3, 16'h0005, 2);
    check("t4 first valid", 32'(res_valid), 32'd1);
    run_trace("t4b", 2, 1, 3, 16'h0002, 0);
    check("t4 overrun set", 32'(overrun), 32'd1);
    check("t4 stopped", 32'(busy), 32'd0);
    check("t4 data held", 32'(res_data), 32'(exp_q[0]));
    take_result("t4 held");
    check("t4 overrun sticky", 32'(overrun), 32'd1);
    start_conv(1, 1, 2, 1'b0, 16'h0003);
    check("t4 overrun cleared", 32'(overrun), 32'd0);
    run_trace("t4c", 1, 1, 2, 16'h0003, 0);
    take_result("t4c");

    // ncomp above NBITS clamps to 16 compares; result left pending.
    start_conv(1, 1, 20, 1'b0, 16'hFFFF);
    run_trace("t3", 1, 1, 20, 16'hFFFF, 1);
    check("t3 valid", 32'(res_valid), 32'd1);

    // Abort beats a simultaneous start.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort+start busy", 32'(busy), 32'd0);
    check("abort+start phases", 32'(phases()), 32'd0);

    // Abort during the third COMP.
    start_conv(1, 1, 5, 1'b0, 16'h0015);
    repeat (6) begin
      comp_in = 1'($urandom);
      tick();
    end
    check("t5 third comp", 32'(phases()), 32'b0010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    void'(exp_q.pop_back());
    check("t5 phases off", 32'(phases()), 32'd0);
    check("t5 busy", 32'(busy), 32'd0);
    check("t5 valid kept", 32'(res_valid), 32'd1);
    check("t5 data kept", 32'(res_data), 32'(exp_q[0]));
    take_result("t3");
    start_conv(2, 3, 6, 1'b0, 16'h002D);
    run_trace("t5r", 2, 3, 6, 16'h002D, 1);
    check("t5r valid", 32'(res_valid), 32'd1);
    check("t5r data", 32'(res_data), 32'(exp_q.pop_front()));

    // Asynchronous reset in the middle of SAMP.
    start_conv(1, 5, 2, 1'b0, 16'h0003);
    tick();
    check("t6 in samp", 32'(phases()), 32'b0100);
    #2 rst_b = 1'b0;
    #1;
    check("t6 phases", 32'(phases()), 32'd0);
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 valid", 32'(res_valid), 32'd0);
    check("t6 data", 32'(res_data), 32'd0);
    check("t6 overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    tick();
    rst_b = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
